// File: rtl/write_buffer.sv
// Byte-to-word write path: packs a byte stream little-endian into 16-bit words,
// queues up to two of them and hands each to the SDRAM controller with a CMD/DONE handshake.
module write_buffer #(
    parameter int unsigned WORDS_PER_ROW = 512,
    parameter logic [7:0]  PAD_BYTE      = 8'h00
) (
    input  logic        CLK_48MHZ,
    input  logic        RESET,
    input  logic [7:0]  BYTE_IN,
    input  logic        BYTE_VALID,
    input  logic        FLUSH,
    input  logic        WRITE_DONE,
    output logic        WRITE_CMD,
    output logic [15:0] DATA_WRITE,
    output logic [8:0]  COL_WRITE,
    output logic [12:0] ROW_WRITE,
    output logic        FULL,
    output logic        OVERFLOW,
    output logic        BUSY
);

    localparam logic [8:0]  COL_LAST = 9'(WORDS_PER_ROW - 1);
    localparam logic [12:0] ROW_LAST = 13'd8191;

    typedef enum logic {IDLE, WRITE} state_t;

    state_t      state_q, state_d;
    logic        write_cmd_q, write_cmd_d;
    logic [15:0] data_write_q, data_write_d;
    logic [8:0]  col_q, col_d;
    logic [12:0] row_q, row_d;
    logic        full_q, full_d;
    logic        overflow_q, overflow_d;
    logic [7:0]  low_q, low_d;
    logic        pending_q, pending_d;
    logic [15:0] mem_q [2];
    logic [15:0] mem_d [2];
    logic        wr_ptr_q, wr_ptr_d;
    logic        rd_ptr_q, rd_ptr_d;
    logic [1:0]  count_q, count_d;

    logic        pop;
    logic        push;
    logic        space;
    logic [15:0] push_word;

    always_comb begin
        // NOTE: every signal gets a default first so no path can infer a latch.
        state_d      = state_q;
        write_cmd_d  = write_cmd_q;
        data_write_d = data_write_q;
        col_d        = col_q;
        row_d        = row_q;
        full_d       = full_q;
        overflow_d   = overflow_q;
        low_d        = low_q;
        pending_d    = pending_q;
        mem_d        = mem_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        pop          = 1'b0;
        push         = 1'b0;
        push_word    = '0;

        // The in-flight word stays at the queue head until the controller acknowledges it.
        case (state_q)
            IDLE: begin
                if (count_q != 2'd0 && !full_q) begin
                    state_d      = WRITE;
                    write_cmd_d  = 1'b1;
                    data_write_d = mem_q[rd_ptr_q];
                end
            end
            WRITE: begin
                if (WRITE_DONE) begin
                    state_d     = IDLE;
                    write_cmd_d = 1'b0;
                    pop         = 1'b1;
                    if (col_q == COL_LAST) begin
                        col_d = '0;
                        if (row_q == ROW_LAST) full_d = 1'b1;
                        else                   row_d  = row_q + 13'd1;
                    end else begin
                        col_d = col_q + 9'd1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        space = (count_q != 2'd2) || pop;

        if (BYTE_VALID) begin
            if (full_q) begin
                overflow_d = 1'b1;
            end else if (!pending_q) begin
                low_d     = BYTE_IN;
                pending_d = 1'b1;
            end else if (space) begin
                push      = 1'b1;
                push_word = {BYTE_IN, low_q};
                pending_d = 1'b0;
            end else begin
                overflow_d = 1'b1;
            end
        end

        // FLUSH sees the pending state left by a same-cycle byte.
        if (FLUSH && pending_d) begin
            if (space) begin
                push      = 1'b1;
                push_word = {PAD_BYTE, low_d};
                pending_d = 1'b0;
            end else begin
                overflow_d = 1'b1;
            end
        end

        if (push) begin
            mem_d[wr_ptr_q] = push_word;
            wr_ptr_d        = ~wr_ptr_q;
        end
        if (pop) rd_ptr_d = ~rd_ptr_q;
        count_d = count_q + {1'b0, push} - {1'b0, pop};
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge CLK_48MHZ) begin
        if (RESET) begin
            state_q      <= IDLE;
            write_cmd_q  <= 1'b0;
            data_write_q <= '0;
            col_q        <= '0;
            row_q        <= '0;
            full_q       <= 1'b0;
            overflow_q   <= 1'b0;
            low_q        <= '0;
            pending_q    <= 1'b0;
            wr_ptr_q     <= 1'b0;
            rd_ptr_q     <= 1'b0;
            count_q      <= '0;
        end else begin
            state_q      <= state_d;
            write_cmd_q  <= write_cmd_d;
            data_write_q <= data_write_d;
            col_q        <= col_d;
            row_q        <= row_d;
            full_q       <= full_d;
            overflow_q   <= overflow_d;
            low_q        <= low_d;
            pending_q    <= pending_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            count_q      <= count_d;
        end
    end

    // NOTE: queue storage is not reset; count_q alone decides which entries are valid.
    always_ff @(posedge CLK_48MHZ) begin
        mem_q <= mem_d;
    end

    assign WRITE_CMD  = write_cmd_q;
    assign DATA_WRITE = data_write_q;
    assign COL_WRITE  = col_q;
    assign ROW_WRITE  = row_q;
    assign FULL       = full_q;
    assign OVERFLOW   = overflow_q;
    assign BUSY       = (count_q != 2'd0) || pending_q || write_cmd_q;

endmodule

// File: tb/tb_write_buffer.sv
// Bench for write_buffer: directed and random traffic against a transaction-level model,
// plus a second instance with short rows driven until the memory fills.
module tb_write_buffer;

    localparam int unsigned WPR_A = 4;
    localparam logic [7:0]  PAD_A = 8'hEE;
    localparam int unsigned WPR_B = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, byte_valid, flush, write_done;
    logic [7:0]  byte_in;
    logic        write_cmd, full, overflow, busy;
    logic [15:0] data_write;
    logic [8:0]  col_write;
    logic [12:0] row_write;

    logic        f_reset, f_byte_valid, f_flush, f_write_done;
    logic [7:0]  f_byte_in;
    logic        f_write_cmd, f_full, f_overflow, f_busy;
    logic [15:0] f_data_write;
    logic [8:0]  f_col_write;
    logic [12:0] f_row_write;

    write_buffer #(.WORDS_PER_ROW(WPR_A), .PAD_BYTE(PAD_A)) dut (
        .CLK_48MHZ(clk), .RESET(reset), .BYTE_IN(byte_in), .BYTE_VALID(byte_valid),
        .FLUSH(flush), .WRITE_DONE(write_done), .WRITE_CMD(write_cmd),
        .DATA_WRITE(data_write), .COL_WRITE(col_write), .ROW_WRITE(row_write),
        .FULL(full), .OVERFLOW(overflow), .BUSY(busy)
    );

    write_buffer #(.WORDS_PER_ROW(WPR_B)) dut_full (
        .CLK_48MHZ(clk), .RESET(f_reset), .BYTE_IN(f_byte_in), .BYTE_VALID(f_byte_valid),
        .FLUSH(f_flush), .WRITE_DONE(f_write_done), .WRITE_CMD(f_write_cmd),
        .DATA_WRITE(f_data_write), .COL_WRITE(f_col_write), .ROW_WRITE(f_row_write),
        .FULL(f_full), .OVERFLOW(f_overflow), .BUSY(f_busy)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Transaction-level reference: a word queue, a pending byte and a count of completed writes.
    logic [15:0] mq [$];
    logic        m_pend, m_ovf, m_cmd;
    logic [7:0]  m_low;
    logic [15:0] m_data;
    int unsigned m_n;

    function automatic logic m_full();
        return m_n >= 8192 * WPR_A;
    endfunction

    function automatic logic [31:0] m_col();
        return m_n % WPR_A;
    endfunction

    function automatic logic [31:0] m_row();
        return (m_n / WPR_A > 8191) ? 32'd8191 : m_n / WPR_A;
    endfunction

    task automatic model_edge(input logic bv, input logic [7:0] b, input logic fl,
                              input logic wd, input logic rst);
        int   pre_size;
        logic pre_cmd, pre_full;
        if (rst) begin
            mq.delete();
            m_pend = 0; m_low = 0; m_ovf = 0; m_cmd = 0; m_data = 0; m_n = 0;
            return;
        end
        pre_cmd  = m_cmd;
        pre_size = mq.size();
        pre_full = m_full();
        if (pre_cmd && wd) begin
            void'(mq.pop_front());
            m_n++;
            m_cmd = 0;
        end else if (!pre_cmd && pre_size > 0 && !pre_full) begin
            m_cmd  = 1;
            m_data = mq[0];
        end
        if (bv) begin
            if (pre_full)          m_ovf = 1;
            else if (!m_pend)      begin m_low = b; m_pend = 1; end
            else if (mq.size() < 2) begin mq.push_back({b, m_low}); m_pend = 0; end
            else                   m_ovf = 1;
        end
        if (fl && m_pend) begin
            if (mq.size() < 2) begin mq.push_back({PAD_A, m_low}); m_pend = 0; end
            else               m_ovf = 1;
        end
    endtask

    task automatic compare_all();
        check("cmd",      32'(write_cmd),  32'(m_cmd));
        check("data",     32'(data_write), 32'(m_data));
        check("col",      32'(col_write),  m_col());
        check("row",      32'(row_write),  m_row());
        check("full",     32'(full),       32'(m_full()));
        check("overflow", 32'(overflow),   32'(m_ovf));
        check("busy",     32'(busy),       32'(mq.size() > 0 || m_pend || m_cmd));
    endtask

    task automatic tick(input logic bv, input logic [7:0] b, input logic fl,
                        input logic wd, input logic rst);
        byte_valid = bv; byte_in = b; flush = fl; write_done = wd; reset = rst;
        @(posedge clk);
        model_edge(bv, b, fl, wd, rst);
        #1;
        compare_all();
    endtask

    initial begin
        int unsigned bytes_sent, writes, cycles;
        logic bv, fl, wd;

        reset = 1; byte_valid = 0; byte_in = 0; flush = 0; write_done = 0;
        f_reset = 1; f_byte_valid = 0; f_byte_in = 0; f_flush = 0; f_write_done = 0;

        // Reset state
        tick(0, 0, 0, 0, 1);
        tick(0, 0, 0, 0, 1);
        check("rst_data", 32'(data_write), 0);
        check("rst_busy", 32'(busy), 0);

        // Single word, acknowledged three cycles after the request rises
        tick(1, 8'h11, 0, 0, 0);
        tick(1, 8'h22, 0, 0, 0);
        check("t1_cmd_latency_low", 32'(write_cmd), 0);
        tick(0, 0, 0, 0, 0);
        check("t1_cmd_rise", 32'(write_cmd), 1);
        check("t1_data", 32'(data_write), 32'h2211);
        tick(0, 0, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        check("t1_cmd_held", 32'(write_cmd), 1);
        tick(0, 0, 0, 1, 0);
        check("t1_cmd_fall", 32'(write_cmd), 0);
        check("t1_col", 32'(col_write), 1);
        check("t1_busy_fall", 32'(busy), 0);

        // Nine words with immediate acknowledge: row wrap at WORDS_PER_ROW=4
        tick(0, 0, 0, 0, 1);
        for (int w = 0; w < 9; w++) begin
            tick(1, 8'(2 * w), 0, 0, 0);
            tick(1, 8'(2 * w + 1), 0, 0, 0);
            tick(0, 0, 0, 0, 0);
            check("t2_data", 32'(data_write), {16'h0, 8'(2 * w + 1), 8'(2 * w)});
            tick(0, 0, 0, 1, 0);
            check("t2_cmd_gap", 32'(write_cmd), 0);
        end
        check("t2_row", 32'(row_write), 2);
        check("t2_col", 32'(col_write), 1);

        // Back-pressure: queue fills, sixth byte dropped, pending low kept
        tick(0, 0, 0, 0, 1);
        for (int i = 1; i <= 6; i++) tick(1, 8'(i), 0, 0, 0);
        check("t3_overflow", 32'(overflow), 1);
        check("t3_head", 32'(data_write), 32'h0201);
        tick(1, 8'h07, 0, 1, 0);
        tick(0, 0, 0, 0, 0);
        check("t3_second", 32'(data_write), 32'h0403);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 0, 0, 0);
        check("t3_third", 32'(data_write), 32'h0705);
        tick(0, 0, 0, 1, 0);
        check("t3_col", 32'(col_write), 3);

        // FLUSH pads a half word; FLUSH with nothing pending is a no-op
        tick(0, 0, 0, 0, 1);
        tick(1, 8'hAB, 0, 0, 0);
        tick(0, 0, 1, 0, 0);
        tick(0, 0, 0, 0, 0);
        check("t4_pad", 32'(data_write), 32'hEEAB);
        tick(0, 0, 0, 1, 0);
        tick(0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            tick(0, 0, 0, 0, 0);
            check("t4_no_write", 32'(write_cmd), 0);
        end
        tick(1, 8'hCD, 1, 0, 0);
        tick(0, 0, 0, 0, 0);
        check("t4_byte_then_flush", 32'(data_write), 32'hEECD);
        tick(0, 0, 0, 1, 0);
        check("t4_col", 32'(col_write), 2);

        // Reset in the middle of a write; a late acknowledge is ignored
        tick(1, 8'h33, 0, 0, 0);
        tick(1, 8'h44, 0, 0, 0);
        tick(0, 0, 0, 0, 0);
        check("t5_cmd_active", 32'(write_cmd), 1);
        tick(0, 0, 0, 0, 1);
        check("t5_cmd", 32'(write_cmd), 0);
        check("t5_col", 32'(col_write), 0);
        check("t5_row", 32'(row_write), 0);
        check("t5_busy", 32'(busy), 0);
        tick(0, 0, 0, 1, 0);
        check("t5_done_ignored", 32'(col_write), 0);

        // Random traffic against the model
        for (int i = 0; i < 400; i++) begin
            bv = $urandom_range(0, 1);
            fl = (mq.size() < 2) && ($urandom_range(0, 9) == 0);
            wd = m_cmd ? ($urandom_range(0, 1) == 1) : ($urandom_range(0, 4) == 0);
            tick(bv, 8'($urandom), fl, wd, 0);
        end

        // Memory exhaustion on the short-row instance
        @(posedge clk); #1;
        f_reset = 0;
        bytes_sent = 0; writes = 0; cycles = 0;
        while (writes < 16384 && cycles < 40000) begin
            f_write_done = f_write_cmd;
            if (f_write_cmd) begin
                if (writes == 16383) begin
                    check("t6_pre_row", 32'(f_row_write), 8191);
                    check("t6_pre_col", 32'(f_col_write), 1);
                    check("t6_pre_full", 32'(f_full), 0);
                end
                writes++;
            end
            f_byte_valid = (bytes_sent < 32768);
            f_byte_in    = 8'(bytes_sent);
            if (f_byte_valid) bytes_sent++;
            @(posedge clk); #1;
            cycles++;
        end
        f_write_done = 0; f_byte_valid = 0;
        check("t6_writes_in_budget", writes, 16384);
        check("t6_full", 32'(f_full), 1);
        check("t6_row_hold", 32'(f_row_write), 8191);
        check("t6_col_wrap", 32'(f_col_write), 0);
        check("t6_no_overflow_yet", 32'(f_overflow), 0);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("t6_no_cmd", 32'(f_write_cmd), 0);
        end
        f_byte_valid = 1; f_byte_in = 8'h5A;
        @(posedge clk); #1;
        f_byte_valid = 0;
        check("t6_overflow", 32'(f_overflow), 1);
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            check("t6_no_cmd_after", 32'(f_write_cmd), 0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
